// File: rtl/dff8_areset.sv
// dff8_areset: byte-wide holding register that captures d on every rising
// clock edge and clears to RESET_VALUE asynchronously while areset is low.
// q is driven straight from the flops; there is no combinational d->q path.
module dff8_areset #(
  parameter int unsigned          WIDTH       = 8,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Next value is simply the incoming byte; no enable, every edge samples.
  always_comb begin
    q_d = d;
  end

  // Storage: low areset forces RESET_VALUE immediately and overrides any
  // coincident rising edge; otherwise capture on the rising clock edge.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_dff8_areset.sv
// tb_dff8_areset: directed checks of async clear, release, capture and hold,
// followed by a randomized soak compared against a behavioural model.
module tb_dff8_areset;

  logic       clk;
  logic       areset;
  logic [7:0] d;
  logic [7:0] q;

  int tests_run;
  int tests_failed;

  logic [7:0] model_q;
  logic [7:0] prev_q;
  logic [7:0] pattern [4];

  dff8_areset #(
    .WIDTH       (8),
    .RESET_VALUE (8'h00)
  ) dut (
    .clk    (clk),
    .areset (areset),
    .d      (d),
    .q      (q)
  );

  // Free-running clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    pattern[0] = 8'h01;
    pattern[1] = 8'h80;
    pattern[2] = 8'hAA;
    pattern[3] = 8'h55;

    // Power-up with reset asserted.
    areset = 1'b0;
    d      = 8'h00;
    #1;
    check("reset_state", q, 8'h00);

    // Release reset away from a rising edge and load 0x5A.
    @(negedge clk);
    areset = 1'b1;
    d      = 8'h5A;
    @(posedge clk); #1;
    check("load_5a", q, 8'h5A);

    // Asynchronous clear at the falling edge.
    @(negedge clk);
    areset = 1'b0;
    #1;
    check("async_clear_negedge", q, 8'h00);
    d = 8'hFF;
    @(posedge clk); #1;
    check("reset_hold_edge1", q, 8'h00);
    @(posedge clk); #1;
    check("reset_hold_edge2", q, 8'h00);

    // Release mid-cycle with d = 0x3C.
    @(negedge clk);
    #2;
    areset = 1'b1;
    d      = 8'h3C;
    #1;
    check("release_no_change", q, 8'h00);
    @(posedge clk); #1;
    check("capture_after_release", q, 8'h3C);

    // Back-to-back data.
    for (int i = 0; i < 4; i++) begin
      prev_q = (i == 0) ? 8'h3C : pattern[i-1];
      @(negedge clk);
      d = pattern[i];
      #1;
      check("b2b_hold", q, prev_q);
      @(posedge clk); #1;
      check("b2b_capture", q, pattern[i]);
    end

    // Hold between edges.
    @(negedge clk);
    d = 8'h12;
    @(posedge clk); #1;
    check("hold_capture_12", q, 8'h12);
    @(negedge clk);
    d = 8'h34;
    #1;
    check("hold_between_edges", q, 8'h12);
    @(posedge clk); #1;
    check("hold_capture_34", q, 8'h34);

    // Reset asserted coincident with a rising edge: reset wins.
    @(negedge clk);
    d = 8'hC3;
    @(posedge clk);
    areset = 1'b0;
    #1;
    check("reset_at_rise", q, 8'h00);

    // Random soak: 400 half-cycles, inputs change 2 time units after each edge.
    @(negedge clk);
    model_q = 8'h00;
    areset  = 1'b1;
    d       = 8'($urandom);
    for (int i = 0; i < 400; i++) begin
      @(clk);
      if (!areset)
        model_q = 8'h00;
      else if (clk === 1'b1)
        model_q = d;
      #1;
      check(clk ? "soak_rise" : "soak_fall", q, model_q);
      #1;
      d      = 8'($urandom);
      areset = ($urandom_range(15) == 0) ? 1'b0 : 1'b1;
      if (!areset) begin
        model_q = 8'h00;
        #1;
        check("soak_async_clear", q, model_q);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
